// File: rtl/poly1305_mac_sequencer.sv
// Poly1305 MAC sequencer.
// Holds the clamped key, accumulates message blocks through a bit-serial
// multiply, hands each product to an external mod 2^130-5 reducer, and turns
// the final accumulator into the 128-bit tag.
//
// Handshakes:
//   blk_valid/blk_ready : a block transfers on a rising edge where both are 1;
//                         blk_ready is high only while the sequencer is IDLE
//                         (and not during the first cycle after reset).
//   red_start/red_busy  : red_start is a one-cycle pulse issued only on a
//                         cycle where red_busy was low; red_value holds the
//                         product from that pulse until the next one.
//   red_done            : accepted only while waiting for a reduction.
module poly1305_mac_sequencer #(
    parameter int MUL_ITERS = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         key_load,
    input  logic [127:0] key_r,
    input  logic [127:0] key_s,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    input  logic [4:0]   blk_len,
    input  logic         blk_last,
    output logic         red_start,
    output logic [257:0] red_value,
    input  logic         red_busy,
    input  logic         red_done,
    input  logic [129:0] red_result,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         busy,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_MUL      = 3'd2,
        ST_RED_REQ  = 3'd3,
        ST_RED_WAIT = 3'd4,
        ST_FINAL    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [127:0] R_CLAMP  = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [129:0] P1305    = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
    localparam logic [6:0]   CNT_LAST = 7'(MUL_ITERS - 1);

    state_t         state_q;
    logic           ready_en_q;
    logic [127:0]   r_q;
    logic [127:0]   s_q;
    logic [129:0]   acc_q;
    logic [128:0]   blk_q;
    logic           last_q;
    logic [130:0]   sum_q;
    logic [257:0]   product_q;
    logic [6:0]     cnt_q;
    logic           red_start_q;
    logic [257:0]   red_value_q;
    logic [127:0]   tag_q;
    logic           tag_valid_q;

    logic [4:0]     len_eff;
    logic [128:0]   blk_val_d;
    logic [130:0]   sum_d;
    logic [257:0]   product_d;
    logic [129:0]   h_d;

    // Block value: the valid low bytes of blk_data with a 1 appended just above them.
    always_comb begin
        blk_val_d = '0;
        len_eff   = (blk_len > 5'd16) ? 5'd16 : blk_len;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < len_eff) begin
                blk_val_d[8*i +: 8] = blk_data[8*i +: 8];
            end
        end
        blk_val_d[{len_eff, 3'b000}] = 1'b1;
    end

    // Arithmetic for the ADD, MUL and FINAL steps.
    always_comb begin
        sum_d     = {1'b0, acc_q} + {2'b00, blk_q};
        product_d = product_q;
        if (r_q[cnt_q]) begin
            product_d = product_q + ({127'd0, sum_q} << cnt_q);
        end
        h_d = (acc_q >= P1305) ? (acc_q - P1305) : acc_q;
    end

    // Sequencer FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ready_en_q  <= 1'b0;
            r_q         <= '0;
            s_q         <= '0;
            acc_q       <= '0;
            blk_q       <= '0;
            last_q      <= 1'b0;
            sum_q       <= '0;
            product_q   <= '0;
            cnt_q       <= '0;
            red_start_q <= 1'b0;
            red_value_q <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            ready_en_q  <= 1'b1;
            red_start_q <= 1'b0;
            tag_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A key update only lands between messages' blocks.
                    if (key_load) begin
                        r_q   <= key_r & R_CLAMP;
                        s_q   <= key_s;
                        acc_q <= '0;
                    end
                    if (blk_valid && blk_ready) begin
                        blk_q  <= blk_val_d;
                        last_q <= blk_last;
                        if (len_eff != 5'd0) begin
                            state_q <= ST_ADD;
                        end else if (blk_last) begin
                            state_q <= ST_FINAL;
                        end
                    end
                end
                ST_ADD: begin
                    sum_q     <= sum_d;
                    product_q <= '0;
                    cnt_q     <= '0;
                    state_q   <= ST_MUL;
                end
                ST_MUL: begin
                    product_q <= product_d;
                    cnt_q     <= cnt_q + 7'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RED_REQ;
                    end
                end
                ST_RED_REQ: begin
                    if (!red_busy) begin
                        red_value_q <= product_q;
                        red_start_q <= 1'b1;
                        state_q     <= ST_RED_WAIT;
                    end
                end
                ST_RED_WAIT: begin
                    if (red_done) begin
                        acc_q   <= red_result;
                        state_q <= last_q ? ST_FINAL : ST_IDLE;
                    end
                end
                ST_FINAL: begin
                    // Conditional subtract gives the fully reduced h, then add s mod 2^128.
                    tag_q       <= 128'(h_d + {2'b00, s_q});
                    tag_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    acc_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign blk_ready   = ready_en_q && (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign red_start   = red_start_q;
    assign red_value   = red_value_q;
    assign tag         = tag_q;
    assign tag_valid   = tag_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_poly1305_mac_sequencer.sv
// Bench for poly1305_mac_sequencer: a Poly1305 reference model in plain
// wide arithmetic, a behavioural 2-cycle reducer, a per-cycle output checker,
// and directed scenarios with literal expectations.
module tb_poly1305_mac_sequencer;

    localparam logic [259:0] P260    = (260'd1 << 130) - 260'd5;
    localparam logic [127:0] CLAMP   = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
    localparam logic [127:0] RFC_R   = 128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] RFC_S   = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [127:0] RFC_B1  = 128'h6f4620636968706172676f7470797243;
    localparam logic [127:0] RFC_B2  = 128'h6f7247206863726165736552206d7572;
    localparam logic [127:0] RFC_B3  = 128'h00000000000000000000000000007075;

    // ---------------- clock / reset / DUT ----------------
    logic         clk;
    logic         reset_n;
    logic         key_load;
    logic [127:0] key_r;
    logic [127:0] key_s;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic [4:0]   blk_len;
    logic         blk_last;
    logic         red_start;
    logic [257:0] red_value;
    logic         red_busy;
    logic         red_done;
    logic [129:0] red_result;
    logic [127:0] tag;
    logic         tag_valid;
    logic         busy;
    logic [2:0]   dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    poly1305_mac_sequencer #(.MUL_ITERS(128)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_load   (key_load),
        .key_r      (key_r),
        .key_s      (key_s),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_len    (blk_len),
        .blk_last   (blk_last),
        .red_start  (red_start),
        .red_value  (red_value),
        .red_busy   (red_busy),
        .red_done   (red_done),
        .red_result (red_result),
        .tag        (tag),
        .tag_valid  (tag_valid),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int n_xfer = 0;
    int n_start = 0;
    int n_tagv = 0;

    logic [257:0] exp_prod_q[$];
    logic [127:0] exp_q[$];

    logic [259:0] m_acc;
    logic [259:0] m_r;
    logic [127:0] m_s;
    logic [127:0] m_last_tag;
    logic         red_override;
    logic [259:0] red_ov_val;

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_key(input logic [127:0] kr, input logic [127:0] ks);
        m_r   = {132'd0, kr & CLAMP};
        m_s   = ks;
        m_acc = '0;
    endtask

    task automatic model_finish();
        logic [259:0] t;
        t = (m_acc % P260) + {132'd0, m_s};
        m_last_tag = t[127:0];
        exp_q.push_back(t[127:0]);
        m_acc = '0;
    endtask

    task automatic model_accept(input logic [127:0] data, input logic [4:0] len, input logic last);
        int le;
        logic [259:0] bv;
        logic [259:0] prod;
        le = (len > 5'd16) ? 16 : int'(len);
        if (le != 0) begin
            bv   = ({132'd0, data} & ((260'd1 << (8 * le)) - 260'd1)) + (260'd1 << (8 * le));
            prod = (m_acc + bv) * m_r;
            exp_prod_q.push_back(prod[257:0]);
            if (red_override) m_acc = red_ov_val;
            else              m_acc = prod % P260;
        end
        if (last) model_finish();
    endtask

    // ---------------- behavioural reducer (result 2 cycles after capture) ----------------
    initial begin
        logic         pend;
        int           wait_n;
        logic [259:0] val;
        logic [259:0] rem;
        pend = 1'b0;
        wait_n = 0;
        val = '0;
        red_done = 1'b0;
        red_result = '0;
        forever begin
            @(negedge clk);
            red_done = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (wait_n == 0) begin
                        rem = val % P260;
                        red_result = red_override ? red_ov_val[129:0] : rem[129:0];
                        red_done = 1'b1;
                        pend = 1'b0;
                    end else begin
                        wait_n--;
                    end
                end
                if (red_start) begin
                    pend = 1'b1;
                    wait_n = 1;
                    val = {2'b00, red_value};
                end
            end
        end
    end

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            if (blk_valid && blk_ready) n_xfer++;
            chk("ready_while_busy", {259'd0, blk_ready && busy}, 260'd0);
            if (red_start) begin
                n_start++;
                if (exp_prod_q.size() == 0) chk("red_value_unexpected", {2'b00, red_value}, 260'd0 - 260'd1);
                else chk("red_value", {2'b00, red_value}, {2'b00, exp_prod_q.pop_front()});
            end
            if (tag_valid) begin
                n_tagv++;
                if (exp_q.size() == 0) chk("tag_unexpected", {132'd0, tag}, 260'd0 - 260'd1);
                else chk("tag", {132'd0, tag}, {132'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_key(input logic [127:0] kr, input logic [127:0] ks);
        key_r = kr;
        key_s = ks;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        model_key(kr, ks);
    endtask

    // Key strobe that must be ignored because the sequencer is busy.
    task automatic poke_key(input logic [127:0] kr, input logic [127:0] ks);
        key_r = kr;
        key_s = ks;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Leaves blk_valid high; the caller drops it when the stream pauses.
    task automatic send_block(input logic [127:0] data, input logic [4:0] len, input logic last);
        int n;
        n = 0;
        blk_data = data;
        blk_len = len;
        blk_last = last;
        blk_valid = 1'b1;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", {259'd0, blk_ready}, 260'd1);
        if (blk_ready) model_accept(data, len, last);
        @(negedge clk);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (!blk_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!blk_ready) $display("FAIL idle_timeout: state %0d still busy after %0d cycles", dbg_state, cyc);
        chk("idle_wait", {259'd0, blk_ready}, 260'd1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cyc;
        int s0;
        int t0;
        int x0;
        reset_n = 1'b0;
        key_load = 1'b0;
        key_r = '0;
        key_s = '0;
        blk_valid = 1'b0;
        blk_data = '0;
        blk_len = '0;
        blk_last = 1'b0;
        red_busy = 1'b0;
        red_override = 1'b0;
        red_ov_val = '0;
        m_acc = '0;
        m_r = '0;
        m_s = '0;
        m_last_tag = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_blk_ready", {259'd0, blk_ready}, 260'd0);
        chk("rst_busy", {259'd0, busy}, 260'd0);
        chk("rst_red_start", {259'd0, red_start}, 260'd0);
        chk("rst_tag_valid", {259'd0, tag_valid}, 260'd0);
        chk("rst_tag", {132'd0, tag}, 260'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {259'd0, blk_ready}, 260'd1);

        // RFC 8439 2.5.2 vector with latency measurement on the first block
        load_key(RFC_R, RFC_S);
        chk("model_clamp", m_r, 260'h0806d5400e52447c036d555408bed685);
        send_block(RFC_B1, 5'd16, 1'b0);
        blk_valid = 1'b0;
        wait_idle(cyc);
        chk("block_latency", 260'(cyc), 260'd133);
        send_block(RFC_B2, 5'd16, 1'b0);
        blk_valid = 1'b0;
        send_block(RFC_B3, 5'd2, 1'b1);
        blk_valid = 1'b0;
        wait_idle(cyc);
        chk("rfc_model_tag", {132'd0, m_last_tag}, {132'd0, RFC_TAG});
        chk("rfc_tag", {132'd0, tag}, {132'd0, RFC_TAG});

        // Finalize-only: tag equals s and no reduction is requested
        load_key(RFC_R, 128'h00112233445566778899aabbccddeeff);
        s0 = n_start;
        t0 = n_tagv;
        send_block('0, 5'd0, 1'b1);
        blk_valid = 1'b0;
        wait_idle(cyc);
        chk("fin_only_tag", {132'd0, tag}, 260'h00112233445566778899aabbccddeeff);
        chk("fin_only_pulses", 260'(n_tagv - t0), 260'd1);
        chk("fin_only_no_start", 260'(n_start - s0), 260'd0);

        // Reducer back-pressure on the second RFC block
        load_key(RFC_R, RFC_S);
        send_block(RFC_B1, 5'd16, 1'b0);
        blk_valid = 1'b0;
        wait_idle(cyc);
        red_busy = 1'b1;
        s0 = n_start;
        send_block(RFC_B2, 5'd16, 1'b0);
        blk_valid = 1'b0;
        repeat (149) @(negedge clk);
        chk("stall_no_start", 260'(n_start - s0), 260'd0);
        red_busy = 1'b0;
        wait_idle(cyc);
        chk("stall_one_start", 260'(n_start - s0), 260'd1);
        send_block(RFC_B3, 5'd2, 1'b1);
        blk_valid = 1'b0;
        wait_idle(cyc);
        chk("stall_tag", {132'd0, tag}, {132'd0, RFC_TAG});

        // Full-reduce boundary: accumulator 2^130-3 entering FINAL with s=0
        load_key(RFC_R, '0);
        red_override = 1'b1;
        red_ov_val = (260'd1 << 130) - 260'd3;
        send_block(128'h1234, 5'd2, 1'b1);
        blk_valid = 1'b0;
        wait_idle(cyc);
        red_override = 1'b0;
        chk("boundary_tag", {132'd0, tag}, 260'd2);

        // Back-to-back valid, oversize length, no-op block, ignored key strobe
        load_key(128'h0f0e0d0c0b0a09080706050403020100, 128'hfedcba98765432100123456789abcdef);
        x0 = n_xfer;
        send_block(128'hdeadbeef_01234567_89abcdef_cafef00d, 5'd20, 1'b0);
        send_block(128'h11111111_22222222_33333333_44444444, 5'd5, 1'b0);
        blk_valid = 1'b0;
        wait_idle(cyc);
        chk("two_transfers", 260'(n_xfer - x0), 260'd2);
        send_block(128'h55, 5'd0, 1'b0);
        blk_valid = 1'b0;
        chk("noop_ready", {259'd0, blk_ready}, 260'd1);
        chk("noop_busy", {259'd0, busy}, 260'd0);
        send_block(128'h0123456789abcdef_fedcba9876543210, 5'd16, 1'b0);
        blk_valid = 1'b0;
        repeat (10) @(negedge clk);
        poke_key(128'hffffffff_ffffffff_ffffffff_ffffffff, 128'h5a5a);
        wait_idle(cyc);
        send_block('0, 5'd0, 1'b1);
        blk_valid = 1'b0;
        wait_idle(cyc);

        // Reset in the middle of the multiply (counter at 60)
        send_block(RFC_B1, 5'd16, 1'b0);
        blk_valid = 1'b0;
        repeat (61) @(negedge clk);
        reset_n = 1'b0;
        #1;
        exp_prod_q.delete();
        exp_q.delete();
        m_acc = '0;
        chk("mid_rst_blk_ready", {259'd0, blk_ready}, 260'd0);
        chk("mid_rst_busy", {259'd0, busy}, 260'd0);
        chk("mid_rst_red_start", {259'd0, red_start}, 260'd0);
        chk("mid_rst_tag_valid", {259'd0, tag_valid}, 260'd0);
        chk("mid_rst_tag", {132'd0, tag}, 260'd0);
        chk("mid_rst_red_value", {2'b00, red_value}, 260'd0);
        @(negedge clk);
        reset_n = 1'b1;
        s0 = n_start;
        @(negedge clk);
        chk("mid_rst_ready_next_edge", {259'd0, blk_ready}, 260'd1);
        repeat (200) @(negedge clk);
        chk("mid_rst_no_start", 260'(n_start - s0), 260'd0);

        chk("prod_queue_empty", 260'(exp_prod_q.size()), 260'd0);
        chk("tag_queue_empty", 260'(exp_q.size()), 260'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/poly1305_mac_sequencer.md
POLY1305_MAC_SEQUENCER -- requirements
Module: poly1305_mac_sequencer

Interface
REQ-001 SHALL have parameter MUL_ITERS, default 128, meaning the shift-add multiply iterations, one bit of r per cycle; fixed at 128.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset; it is asynchronous and active-low.
REQ-004 SHALL have port key_load, input, 1, a one-cycle strobe that captures key_r and key_s.
REQ-005 SHALL have ports key_r and key_s, input, 128 each, the raw r half and s half of the key, little-endian bytes (byte 0 = bits[7:0]).
REQ-006 SHALL have ports blk_valid (input, 1) and blk_ready (output, 1), the message-block handshake.
REQ-007 SHALL have ports blk_data (input, 128), blk_len (input, 5, valid bytes 0..16) and blk_last (input, 1, final block).
REQ-008 SHALL have ports red_start (output, 1), red_value (output, 258), red_busy (input, 1), red_done (input, 1) and red_result (input, 130), the initiator side of the mod 2^130-5 reduction unit.
REQ-009 SHALL have ports tag (output, 128), tag_valid (output, 1, one-cycle pulse) and busy (output, 1).

Function
REQ-010 SHALL clamp r on key_load: r = key_r AND 0x0ffffffc0ffffffc0ffffffc0fffffff; SHALL clear acc to 0.
REQ-011 SHALL ignore key_load while busy=1.
REQ-012 SHALL use states IDLE, ADD, MUL, RED_REQ, RED_WAIT, FINAL, DONE.
REQ-013 SHALL assert blk_ready=1 only in IDLE; a transfer occurs when blk_valid and blk_ready are both 1 on an edge.
REQ-014 SHALL form the block value on acceptance as blk_data[8*len-1:0] + 2^(8*len); blk_len 17..31 SHALL be treated as 16.
REQ-015 SHALL treat blk_len=0 with blk_last=1 as "finalize without data": go IDLE->FINAL.
REQ-016 SHALL treat blk_len=0 with blk_last=0 as a no-op: accepted, state stays IDLE.
REQ-017 ADD (1 cycle): sum = acc + block, 131 bits, no truncation.
REQ-018 MUL (exactly 128 cycles, 7-bit counter 0..127): product += sum << i whenever r[i]=1; product is 258 bits and SHALL NOT overflow (sum < 2^131, r < 2^124).
REQ-019 RED_REQ:
- Wait while red_busy=1.
- Once red_busy=0, drive red_value=product and red_start=1 for exactly one cycle.
- Then go to RED_WAIT.
REQ-020 RED_WAIT: on red_done=1, set acc = red_result and hold red_start=0.
- If the block carried blk_last=1, go to FINAL.
- Otherwise go to IDLE.
REQ-021 FINAL (1 cycle):
- If acc >= 2^130-5, set h = acc - (2^130-5); else h = acc.
- tag = (h + s) mod 2^128.
- Go to DONE.
REQ-022 DONE (1 cycle):
- Pulse tag_valid=1; tag holds until the next FINAL.
- Clear acc to 0 and return to IDLE, ready for a new message with the same key.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 red_value SHALL hold its last driven value outside RED_REQ.
REQ-025 Per-block latency from accept to return to IDLE SHALL be 1 + 128 + 1 + reducer latency + 1 cycles; with a 2-cycle reducer this is 133 cycles.
REQ-026 A red_done arriving in any state other than RED_WAIT SHALL be ignored.

Reset
REQ-027 SHALL, on reset_n=0 and regardless of the clock:
- Force IDLE, blk_ready=0 while reset is asserted, red_start=0, tag_valid=0, busy=0.
- Clear tag, red_value, acc, r, s, product and counter to 0.
REQ-028 SHALL abandon any in-flight block when reset arrives mid-operation; after release, a key_load is required before results are meaningful.
REQ-029 blk_ready SHALL be 1 on the first clock edge after reset_n rises.

Verification
REQ-030 RFC 8439 sect. 2.5.2 vector: key r=85d6be7857556d337f4452fe42d506a8, s=0103808afb0db2fd4abff6af4149f51b; message "Cryptographic Forum Research Group" as 16+16+2-byte blocks, last flagged -> tag = a8061dc1305136c6c22b8baf0c0127a9.
REQ-031 Finalize-only: key_load with key_s=0x00112233445566778899aabbccddeeff, then blk_len=0, blk_last=1 -> one tag_valid pulse with tag = s; red_start is never asserted.
REQ-032 Back-pressure: hold red_busy=1 for 20 cycles during RED_REQ -> red_start stays 0; it pulses exactly once after red_busy falls; tag is unchanged from the unstalled run.
REQ-033 Reset mid-MUL: assert reset_n=0 at MUL count 60 -> all outputs are 0 immediately; after release, blk_ready=1 on the next edge and no red_start appears.
REQ-034 Full-reduce boundary: force acc = 2^130-3 entering FINAL with s=0 -> tag = 2.
REQ-035 Handshake: hold blk_valid=1 continuously across two blocks -> exactly two transfers; blk_ready=0 for the whole of each block's processing.
